// File: rtl/fdu_failover_ctrl.sv
// fdu_failover_ctrl
// Picks one active FDU unit out of three, based on the health flags reported
// by the heartbeat watchdogs.
//   - Each raw health bit is filtered before use. A failure is accepted at
//     once, but a recovery is accepted only after DEBOUNCE consecutive
//     healthy samples.
//   - Failover is non-revertive. After any unit-to-unit switch there is a
//     hold-off window during which operator force requests are ignored.
// Ports:
//   clk, reset      system clock; asynchronous active-high reset
//   health[2:0]     raw health, bit i = unit i (same clock domain)
//   force_en        level request to switch to force_sel
//   force_sel[1:0]  forced target 0..2 (3 is ignored)
//   active_sel[1:0] selected unit 0..2, 3 = none
//   active_valid    active_sel is a real unit
//   all_fail        no unit selected
//   switch_pulse    one-cycle pulse whenever active_sel changes
//   switch_count    number of switches, saturating at 255
//   health_filt     filtered health per unit
module fdu_failover_ctrl #(
  parameter int unsigned DEBOUNCE = 1000,
  parameter int unsigned HOLDOFF  = 65000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] health,
  input  logic       force_en,
  input  logic [1:0] force_sel,
  output logic [1:0] active_sel,
  output logic       active_valid,
  output logic       all_fail,
  output logic       switch_pulse,
  output logic [7:0] switch_count,
  output logic [2:0] health_filt
);

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE - 1);
  localparam logic [23:0] HOLD_LOAD = 24'(HOLDOFF - 1);
  localparam logic [1:0]  SEL_NONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_NONE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // Lowest set index of a 3-bit mask; returns 3 when the mask is empty.
  function automatic logic [1:0] lowest_idx(input logic [2:0] mask);
    logic [1:0] idx;
    if (mask[0])      idx = 2'd0;
    else if (mask[1]) idx = 2'd1;
    else if (mask[2]) idx = 2'd2;
    else              idx = SEL_NONE;
    return idx;
  endfunction

  logic [15:0] cnt_q [3];
  logic [15:0] cnt_d [3];
  logic [2:0]  filt_q, filt_d;

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [23:0] hold_q, hold_d;
  logic        valid_q, fail_q, pulse_q;
  logic [7:0]  count_q, count_d;

  logic [3:0]  filt_x;
  logic [2:0]  others;
  logic        force_ok;
  logic        act_ok;
  logic        pulse_d;

  // Asymmetric health filter: a low sample drops at once, a rise needs a run.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i]  = cnt_q[i];
      filt_d[i] = filt_q[i];
      if (!health[i]) begin
        cnt_d[i]  = 16'd0;
        filt_d[i] = 1'b0;
      end else if (filt_q[i]) begin
        cnt_d[i]  = 16'd0;
        filt_d[i] = 1'b1;
      end else if (cnt_q[i] == DEB_LAST) begin
        cnt_d[i]  = 16'd0;
        filt_d[i] = 1'b1;
      end else begin
        cnt_d[i]  = cnt_q[i] + 16'd1;
        filt_d[i] = 1'b0;
      end
    end
  end

  // Failover next-state and selection logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    // filt_x pads a fourth bit so that index 3 safely reads as unhealthy.
    filt_x   = {1'b0, filt_q};
    others   = filt_q & ~(3'b001 << sel_q);
    act_ok   = filt_x[sel_q];
    force_ok = force_en && (force_sel != SEL_NONE) && filt_x[force_sel];
    case (state_q)
      ST_NONE: begin
        if (|filt_q) begin
          sel_d   = force_ok ? force_sel : lowest_idx(filt_q);
          state_d = ST_ACTIVE;
        end else begin
          sel_d   = SEL_NONE;
          state_d = ST_NONE;
        end
      end
      ST_ACTIVE, ST_HOLDOFF: begin
        // A failure of the active unit is handled before any force request.
        if (!act_ok) begin
          if (|others) begin
            sel_d   = lowest_idx(others);
            hold_d  = HOLD_LOAD;
            state_d = ST_HOLDOFF;
          end else begin
            sel_d   = SEL_NONE;
            hold_d  = 24'd0;
            state_d = ST_NONE;
          end
        end else if (state_q == ST_ACTIVE) begin
          if (force_ok && (force_sel != sel_q)) begin
            sel_d   = force_sel;
            hold_d  = HOLD_LOAD;
            state_d = ST_HOLDOFF;
          end else begin
            state_d = ST_ACTIVE;
          end
        end else if (hold_q == 24'd0) begin
          state_d = ST_ACTIVE;
        end else begin
          hold_d = hold_q - 24'd1;
        end
      end
      default: begin
        state_d = ST_NONE;
        sel_d   = SEL_NONE;
        hold_d  = 24'd0;
      end
    endcase
    pulse_d = (sel_d != sel_q);
    if (pulse_d && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // State, filter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= 16'd0;
      filt_q  <= 3'b000;
      state_q <= ST_NONE;
      sel_q   <= SEL_NONE;
      hold_q  <= 24'd0;
      valid_q <= 1'b0;
      fail_q  <= 1'b1;
      pulse_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      filt_q  <= filt_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      valid_q <= (sel_d != SEL_NONE);
      fail_q  <= (sel_d == SEL_NONE);
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  assign active_sel   = sel_q;
  assign active_valid = valid_q;
  assign all_fail     = fail_q;
  assign switch_pulse = pulse_q;
  assign switch_count = count_q;
  assign health_filt  = filt_q;

endmodule

// File: tb/tb_fdu_failover_ctrl.sv
// Testbench for fdu_failover_ctrl with DEBOUNCE=4 and HOLDOFF=16.
// A behavioural model advances once per clock edge. Every output is compared
// with that model after each edge. Literal checks pin the key moments.
module tb_fdu_failover_ctrl;

  localparam int DEB = 4;
  localparam int HO  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] health = 3'b000;
  logic       force_en = 1'b0;
  logic [1:0] force_sel = 2'd0;
  logic [1:0] active_sel;
  logic       active_valid, all_fail, switch_pulse;
  logic [7:0] switch_count;
  logic [2:0] health_filt;

  int errors = 0;
  int checks = 0;

  // Model state: run lengths of healthy samples, selection, last switch edge.
  int m_run [3];
  int m_sel, m_count, m_edge, m_ho_edge;
  bit m_pulse;
  bit [2:0] m_filt;
  int nsw;

  fdu_failover_ctrl #(.DEBOUNCE(DEB), .HOLDOFF(HO)) dut (
    .clk(clk), .reset(reset), .health(health), .force_en(force_en),
    .force_sel(force_sel), .active_sel(active_sel), .active_valid(active_valid),
    .all_fail(all_fail), .switch_pulse(switch_pulse),
    .switch_count(switch_count), .health_filt(health_filt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [2:0] m);
    for (int i = 0; i < 3; i++) if (m[i]) return i;
    return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_filt = 3'b000; m_sel = 3; m_count = 0; m_pulse = 0;
    m_ho_edge = -1000000;
  endtask

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_advance();
    int ns;
    bit [2:0] oth;
    m_edge++;
    if (reset) begin
      model_reset();
      return;
    end
    ns = m_sel;
    if (m_sel == 3) begin
      if (m_filt != 0) begin
        if (force_en && force_sel < 3 && m_filt[force_sel]) ns = force_sel;
        else ns = lowest(m_filt);
      end
    end else if (!m_filt[m_sel]) begin
      oth = m_filt;
      oth[m_sel] = 1'b0;
      if (oth != 0) begin
        ns = lowest(oth);
        m_ho_edge = m_edge;
      end else begin
        ns = 3;
      end
    end else if (force_en && force_sel < 3 && force_sel != m_sel && m_filt[force_sel]
                 && (m_edge - m_ho_edge) >= HO + 1) begin
      ns = force_sel;
      m_ho_edge = m_edge;
    end
    m_pulse = (ns != m_sel);
    if (m_pulse && m_count < 255) m_count++;
    if (m_pulse) nsw++;
    m_sel = ns;
    for (int i = 0; i < 3; i++) begin
      m_run[i] = health[i] ? m_run[i] + 1 : 0;
      if (m_run[i] > 100000) m_run[i] = 100000;
      m_filt[i] = (m_run[i] >= DEB);
    end
  endtask

  task automatic compare_all();
    chk("active_sel", active_sel, m_sel);
    chk("active_valid", active_valid, (m_sel != 3));
    chk("all_fail", all_fail, (m_sel == 3));
    chk("switch_pulse", switch_pulse, m_pulse);
    chk("switch_count", switch_count, m_count);
    chk("health_filt", health_filt, m_filt);
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int guard;
    m_edge = 0;
    nsw = 0;
    model_reset();

    // Reset with all units unhealthy.
    reset = 1'b1; health = 3'b000;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_sel", active_sel, 3);
    chk("rst_all_fail", all_fail, 1);
    chk("rst_count", switch_count, 0);

    // Acquisition. A force_sel of 3 is ignored, so the lowest unit is taken.
    health = 3'b111; force_en = 1'b1; force_sel = 2'd3;
    repeat (4) step();
    chk("acq_filt", health_filt, 3'b111);
    chk("acq_sel_before", active_sel, 3);
    step();
    chk("acq_sel", active_sel, 0);
    chk("acq_valid", active_valid, 1);
    chk("acq_pulse", switch_pulse, 1);
    chk("acq_count", switch_count, 1);
    force_en = 1'b0;

    // Failure of unit 0: failover to unit 1 two edges later.
    health = 3'b110;
    step();
    chk("fail0_filt", health_filt, 3'b110);
    chk("fail0_sel_hold", active_sel, 0);
    step();
    chk("fail0_sel", active_sel, 1);
    chk("fail0_pulse", switch_pulse, 1);
    chk("fail0_count", switch_count, 2);

    // A force request during hold-off is deferred until hold-off ends.
    force_en = 1'b1; force_sel = 2'd2;
    for (int i = 0; i < HO; i++) begin
      step();
      chk("holdoff_hold", active_sel, 1);
    end
    step();
    chk("force_sel2", active_sel, 2);
    chk("force_count", switch_count, 3);
    force_en = 1'b0;

    // Unit 2 fails; unit 1 is the only debounced alternative.
    health = 3'b011;
    step();
    step();
    chk("fail2_sel", active_sel, 1);

    // Short healthy bursts on unit 2 never pass the filter. Unit 0 recovers,
    // but selection is non-revertive, so no switch happens.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        health = {(k < 3), 2'b11};
        step();
        chk("burst_filt2", health_filt[2], 0);
      end
    end
    chk("nonrevert_sel", active_sel, 1);

    // Loss of every unit, then recovery from none.
    health = 3'b000;
    step();
    chk("loss_sel_hold", active_sel, 1);
    step();
    chk("loss_sel", active_sel, 3);
    chk("loss_all_fail", all_fail, 1);
    chk("loss_pulse", switch_pulse, 1);
    health = 3'b110;
    repeat (4) step();
    chk("rec_filt", health_filt, 3'b110);
    step();
    chk("rec_sel", active_sel, 1);
    chk("rec_pulse", switch_pulse, 1);

    // A failure of the active unit beats a force request seen in the same cycle.
    health = 3'b111;
    repeat (4) step();
    health = 3'b101;
    step();
    force_en = 1'b1; force_sel = 2'd2;
    step();
    chk("prio_sel", active_sel, 0);

    // Alternate force targets until more than 255 switches have happened.
    nsw = 0;
    guard = 0;
    while (nsw < 300 && guard < 8000) begin
      force_sel = (m_sel == 2) ? 2'd0 : 2'd2;
      step();
      guard++;
    end
    chk("sat_switches_done", (nsw >= 300), 1);
    chk("sat_count", switch_count, 255);

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_sel", active_sel, 3);
    chk("async_rst_count", switch_count, 0);
    chk("async_rst_filt", health_filt, 3'b000);
    chk("async_rst_fail", all_fail, 1);
    step();
    reset = 1'b0;
    force_en = 1'b0;
    repeat (6) step();
    chk("post_rst_sel", active_sel, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
